// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the instruction loader
package mips_pkg;

  localparam int INSTR_W        = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_FILL,
    S_DONE,
    S_ERR
  } loader_state_t;

  // A load is in progress from the length byte through zero-fill.
  function automatic logic state_busy(input loader_state_t s);
    return (s == S_LEN) || (s == S_DATA) || (s == S_WRITE) || (s == S_FILL);
  endfunction

endpackage

// File: rtl/byte_to_word.sv
// rtl/byte_to_word.sv - big-endian byte-to-word shift assembler
module byte_to_word
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               shift_en,
  input  logic [7:0]         byte_in,
  output logic [INSTR_W-1:0] word,
  output logic               word_valid
);

  logic [1:0] cnt_q;

  // Shift each accepted byte in at the bottom so the first byte ends up as the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      word  <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (shift_en) begin
      word  <= {word[INSTR_W-9:0], byte_in};
      cnt_q <= cnt_q + 2'd1;
    end
  end

  // Flags the byte that completes a word; the word register holds it from the next cycle.
  assign word_valid = shift_en && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - boot-time byte-stream writer for the instruction memory
module instr_loader
  import mips_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               busy,
  output logic               cpu_hold,
  output logic               done,
  output logic               err
);

  // One extra index bit so a full-depth image (N = DEPTH) does not wrap.
  localparam int IDX_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0] FULL_N   = IDX_W'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  loader_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] n_q;

  logic               handshake;
  logic               len_too_big;
  logic               idx_clear;
  logic               idx_inc;
  logic               n_load;
  logic               shift_en;
  logic               word_valid;
  logic [INSTR_W-1:0] asm_word;

  assign handshake   = in_valid && in_ready;
  assign len_too_big = 32'(in_data) > 32'(DEPTH);

  byte_to_word u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (idx_clear),
    .shift_en   (shift_en),
    .byte_in    (in_data),
    .word       (asm_word),
    .word_valid (word_valid)
  );

  // State, word index and latched length.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      if (idx_clear) begin
        idx_q <= '0;
      end else if (idx_inc) begin
        idx_q <= idx_q + IDX_W'(1);
      end
      if (n_load) begin
        n_q <= in_data[IDX_W-1:0];
      end
    end
  end

  // Next-state and datapath controls.
  always_comb begin
    state_d   = state_q;
    idx_clear = 1'b0;
    idx_inc   = 1'b0;
    n_load    = 1'b0;
    shift_en  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d   = S_LEN;
          idx_clear = 1'b1;
        end
      end
      S_LEN: begin
        if (handshake) begin
          n_load = 1'b1;
          if (len_too_big) begin
            state_d = S_ERR;
          end else if (in_data == 8'd0) begin
            state_d = S_FILL;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        shift_en = handshake;
        if (word_valid) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_inc = 1'b1;
        if ((idx_q + IDX_W'(1)) == n_q) begin
          state_d = (n_q == FULL_N) ? S_DONE : S_FILL;
        end else begin
          state_d = S_DATA;
        end
      end
      S_FILL: begin
        idx_inc = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode from state only, so nothing flows combinationally from in_valid.
  always_comb begin
    in_ready = (state_q == S_LEN) || (state_q == S_DATA);
    wr_en    = (state_q == S_WRITE) || (state_q == S_FILL);
    wr_addr  = wr_en ? idx_q[ADDR_W-1:0] : '0;
    wr_data  = (state_q == S_WRITE) ? asm_word : '0;
    busy     = state_busy(state_q);
    cpu_hold = busy;
    done     = (state_q == S_DONE);
    err      = (state_q == S_ERR);
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - scoreboard bench for instr_loader
module tb_instr_loader;
  import mips_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [INSTR_W-1:0] wr_data;
  logic               busy;
  logic               cpu_hold;
  logic               done;
  logic               err;

  instr_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] mem[DEPTH];
  logic [31:0] img[DEPTH];

  // Cycle counter for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory: captures wr_data on the edge that ends a wr_en cycle.
  always @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && wr_en) begin
      check("ready_low_during_write", in_ready, 1'b0);
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: got addr %0d data %08h, expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", wr_data, e.data);
      end
    end
  end

  // Reference model: image words first, zeros for the rest; an oversize length writes nothing.
  task automatic expect_load(input int n, input logic [31:0] words[$]);
    wr_t e;
    if (n > DEPTH) return;
    for (int i = 0; i < DEPTH; i++) begin
      e.addr = ADDR_W'(i);
      e.data = (i < n) ? words[i] : 32'h0;
      img[i] = e.data;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int   g;
    int   tmo;
    logic rdy;
    g   = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    tmo = 0;
    if (g > 0) begin
      in_valid = 1'b0;
      repeat (g) begin
        in_data = 8'($urandom);
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      tmo++;
      if (tmo > 200) begin
        bound_fail("byte_accept");
        break;
      end
    end
  endtask

  task automatic send_words(input int n, input logic [31:0] words[$], input int max_gap);
    logic [31:0] wd;
    for (int i = 0; i < n; i++) begin
      wd = words[i];
      for (int b = 3; b >= 0; b--) send_byte(wd[8*b +: 8], max_gap);
    end
  endtask

  task automatic pulse_start(output int k);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = cyc;
    check("start_flags", {busy, cpu_hold, in_ready, done, err}, 5'b11100);
  endtask

  task automatic run_load(input int n, input logic [31:0] words[$], input int max_gap, input bit timed);
    int k;
    int tmo;
    int bad;
    expect_load(n, words);
    pulse_start(k);
    send_byte(8'(n), max_gap);
    if (n > DEPTH) begin
      in_valid = 1'b0;
      @(negedge clk);
      check("err_flags", {err, done, busy, in_ready, wr_en}, 5'b10000);
      repeat (5) @(posedge clk);
      #1;
      check("err_held", {err, in_ready}, 2'b10);
      return;
    end
    send_words(n, words, max_gap);
    in_valid = 1'b0;
    tmo = 0;
    do begin
      @(negedge clk);
      tmo++;
    end while (!done && tmo < 3000);
    if (!done) bound_fail("done_wait");
    if (timed) check("load_cycles", 64'(cyc - k), 64'(1 + 5*n + DEPTH - n));
    check("done_flags", {done, err, busy, cpu_hold, in_ready, wr_en}, 6'b100000);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== img[i]) bad++;
    check("mem_image_bad_words", 64'(bad), 64'd0);
  endtask

  initial begin
    logic [31:0] w[$];
    int k;
    int n;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {in_ready, wr_en, wr_addr, wr_data, busy, cpu_hold, done, err}, 64'd0);
    rst = 1'b0;

    // Normal two-word load.
    w = {32'h8E510002, 32'h00000000};
    run_load(2, w, 0, 1'b1);

    // Full image, no fill.
    w = {};
    for (int i = 1; i <= DEPTH; i++) w.push_back(32'(i));
    run_load(DEPTH, w, 0, 1'b1);

    // Zero length: fill only.
    w = {};
    run_load(0, w, 0, 1'b1);

    // Oversize length, then recovery with a legal load.
    run_load(DEPTH + 1, w, 0, 1'b0);
    w = {};
    for (int i = 0; i < 5; i++) w.push_back($urandom);
    run_load(5, w, 2, 1'b0);

    // Random lengths and contents with random in_valid gaps.
    for (int t = 0; t < 6; t++) begin
      n = int'($urandom_range(DEPTH, 0));
      w = {};
      for (int i = 0; i < n; i++) w.push_back($urandom);
      run_load(n, w, 3, 1'b0);
    end

    // Reset after six bytes of a three-word load: only word 0 lands.
    w = {32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003};
    exp_q.push_back('{addr: '0, data: 32'hCAFE0001});
    pulse_start(k);
    send_byte(8'd3, 0);
    for (int b = 3; b >= 0; b--) send_byte(8'(32'hCAFE0001 >> (8*b)), 0);
    send_byte(8'hCA, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midload_reset_outputs", {in_ready, wr_en, wr_addr, wr_data, busy, cpu_hold, done, err}, 64'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midload_queue_drained", 64'(exp_q.size()), 64'd0);
    check("midload_idle", {busy, done, err}, 3'b000);

    // Clean reload after the interrupted one.
    run_load(3, w, 2, 1'b0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
